// File: rtl/uart_pixel_packer.sv
// Packs pairs of UART bytes into RGB565 pixels and streams them through a 4-deep buffer to the SDRAM write FIFO.
// Optional gap resync enabled by defining PACKER_TIMEOUT_EN.
module uart_pixel_packer #(
  parameter int IMG_H       = 800,
  parameter int IMG_V       = 480,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        wr_full,
  output logic [15:0] wr_data,
  output logic        wr_en,
  output logic        frame_done,
  output logic        overflow,
  output logic [18:0] pixel_cnt
);

  localparam int FRAME_PIX = IMG_H * IMG_V;

  // Handshake: a pixel leaves on every cycle where wr_en=1; wr_en already
  // accounts for wr_full, so the consumer never has to qualify it.

  typedef enum logic {S_HI, S_LO} state_t;

  state_t      state, state_next;
  logic [7:0]  hi_byte;
  logic [15:0] mem [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  count;
  logic        latch_hi, push_req, push, pop, timeout;

  assign pop     = (count != 3'd0) && !wr_full;
  assign wr_en   = pop;
  assign wr_data = mem[rd_ptr];
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push    = push_req && ((count < 3'd4) || pop);

  always_ff @(posedge clk) begin
    if (rst) state <= S_HI;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch_hi   = 1'b0;
    push_req   = 1'b0;
    case (state)
      S_HI: begin
        if (rx_done) begin
          latch_hi   = 1'b1;
          state_next = S_LO;
        end
      end
      S_LO: begin
        if (rx_done) begin
          push_req   = 1'b1;
          state_next = S_HI;
        end else if (timeout) begin
          state_next = S_HI;
        end
      end
      default: state_next = S_HI;
    endcase
  end

`ifdef PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] gap_cnt;

  // Counts idle cycles spent in S_LO; zero on the first S_LO cycle.
  always_ff @(posedge clk) begin
    if (rst)                 gap_cnt <= '0;
    else if (state == S_LO)  gap_cnt <= gap_cnt + 1'b1;
    else                     gap_cnt <= '0;
  end

  assign timeout = (state == S_LO) && (gap_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_byte <= '0;
    end else if (latch_hi) begin
      hi_byte <= rx_data;
    end else if (timeout && !rx_done) begin
      hi_byte <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {hi_byte, rx_data};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_cnt  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (push) begin
        if (pixel_cnt == 19'(FRAME_PIX - 1)) begin
          pixel_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          pixel_cnt <= pixel_cnt + 19'd1;
        end
      end
      if (push_req && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Randomized and directed bench for uart_pixel_packer against a byte-pair / queue reference model.
// Honours PACKER_TIMEOUT_EN so the model matches whichever build is compiled.
module tb_uart_pixel_packer;

  localparam int IMG_H = 4;
  localparam int IMG_V = 2;
  localparam int TMO   = 100;
  localparam int FRAME = IMG_H * IMG_V;
`ifdef PACKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        wr_full = 1'b0;
  logic [15:0] wr_data;
  logic        wr_en, frame_done, overflow;
  logic [18:0] pixel_cnt;

  uart_pixel_packer #(.IMG_H(IMG_H), .IMG_V(IMG_V), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .wr_full(wr_full),
    .wr_data(wr_data), .wr_en(wr_en), .frame_done(frame_done),
    .overflow(overflow), .pixel_cnt(pixel_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: byte pairing, pixel queue, frame counter
  logic [15:0] exp_q[$];
  logic [15:0] wr_log[$];
  bit          have_hi;
  logic [7:0]  hi;
  int          hi_cyc, pcnt, cyc, fd_seen;
  bit          ovf, fd_exp;

  task automatic model_reset();
    exp_q.delete();
    have_hi = 0; hi = '0; hi_cyc = 0; pcnt = 0; ovf = 0; fd_exp = 0;
  endtask

  task automatic cycle(input bit r, input bit d, input logic [7:0] b, input bit f);
    bit exp_en;
    @(negedge clk);
    rst = r; rx_done = d; rx_data = b; wr_full = f;
    #1;
    exp_en = (exp_q.size() > 0) && !f;
    check("wr_en", wr_en, exp_en);
    if (exp_q.size() > 0) check("wr_data", wr_data, exp_q[0]);
    check("pixel_cnt", pixel_cnt, pcnt);
    check("overflow", overflow, ovf);
    check("frame_done", frame_done, fd_exp);
    if (wr_en) wr_log.push_back(wr_data);
    if (frame_done) fd_seen++;
    if (r) begin
      model_reset();
    end else begin
      fd_exp = 0;
      if (exp_en) void'(exp_q.pop_front());
      if (d) begin
        if (have_hi && (!TO_EN || (cyc - hi_cyc) <= TMO)) begin
          have_hi = 0;
          if (exp_q.size() < 4) begin
            exp_q.push_back({hi, b});
            pcnt++;
            if (pcnt == FRAME) begin
              pcnt   = 0;
              fd_exp = 1;
            end
          end else begin
            ovf = 1;
          end
        end else begin
          have_hi = 1; hi = b; hi_cyc = cyc;
        end
      end else if (TO_EN && have_hi && (cyc - hi_cyc) >= TMO) begin
        have_hi = 0;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit f);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, f);
  endtask

  task automatic do_reset();
    cycle(1, 0, 8'h00, 0);
    @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_pixel_cnt", pixel_cnt, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_done", frame_done, 0);
    wr_log.delete();
    fd_seen = 0;
  endtask

  logic [15:0] px [6];

  initial begin
    cyc = 0; fd_seen = 0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // single pixel latency
    cycle(0, 1, 8'hF8, 0);
    cycle(0, 1, 8'h1F, 0);
    idle(3, 0);
    check("px_log_size", wr_log.size(), 1);
    if (wr_log.size() >= 1) check("px_value", wr_log[0], 16'hF81F);
    check("px_count", pixel_cnt, 1);

    // overflow while the write FIFO is full
    do_reset();
    for (int i = 0; i < 6; i++) begin
      px[i] = 16'($urandom);
      cycle(0, 1, px[i][15:8], 1);
      cycle(0, 1, px[i][7:0], 1);
      idle(1, 1);
    end
    check("ovf_flag", overflow, 1);
    check("ovf_count", pixel_cnt, 4);
    idle(6, 0);
    check("ovf_log_size", wr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (wr_log.size() > i) check("ovf_order", wr_log[i], px[i]);
    check("ovf_sticky", overflow, 1);

    // frame wrap
    do_reset();
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'($urandom), 0);
    idle(4, 0);
    check("frame_pulses", fd_seen, 1);
    check("frame_cnt_wrap", pixel_cnt, 0);

    // long gap after a lone byte
    do_reset();
    cycle(0, 1, 8'hAA, 0);
    idle(150, 0);
    cycle(0, 1, 8'h12, 0);
    cycle(0, 1, 8'h34, 0);
    idle(3, 0);
    check("gap_log_size", wr_log.size(), 1);
    if (wr_log.size() >= 1) check("gap_value", wr_log[0], TO_EN ? 16'h1234 : 16'hAA12);

    // reset in the middle of a pair
    do_reset();
    cycle(0, 1, 8'h77, 0);
    cycle(1, 0, 8'h00, 0);
    idle(3, 0);
    check("rst_mid_log", wr_log.size(), 0);
    cycle(0, 1, 8'h00, 0);
    cycle(0, 1, 8'hFF, 0);
    idle(3, 0);
    check("rst_mid_log2", wr_log.size(), 1);
    if (wr_log.size() >= 1) check("rst_mid_value", wr_log[0], 16'h00FF);

    // second byte exactly at the timeout boundary
    do_reset();
    cycle(0, 1, 8'h0F, 0);
    idle(TMO - 1, 0);
    cycle(0, 1, 8'h55, 0);
    idle(3, 0);
    check("edge_log_size", wr_log.size(), 1);
    if (wr_log.size() >= 1) check("edge_value", wr_log[0], 16'h0F55);

    // random traffic with back-pressure, gaps and occasional resets
    do_reset();
    begin
      bit f;
      f = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 15) == 0) f = ~f;
        if ($urandom_range(0, 399) == 0) begin
          cycle(1, 0, 8'h00, f);
        end else if ($urandom_range(0, 199) == 0) begin
          idle($urandom_range(TMO - 3, TMO + 3), f);
        end else begin
          cycle(0, ($urandom_range(0, 2) == 0), 8'($urandom), f);
        end
      end
      idle(8, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_pixel_packer.md
UART_PIXEL_PACKER -- requirements
Module: uart_pixel_packer

Interface
REQ-001 Parameter IMG_H, default 800: active pixels per line.
REQ-002 Parameter IMG_V, default 480: active lines per frame.
REQ-003 Parameter TIMEOUT_CYC, default 50000: inter-byte gap limit, in clk cycles.
REQ-004 Port clk, input, 1: single clock, the uart_rx clock domain (clk_50M); all logic is on the rising edge.
REQ-005 Port rst, input, 1: synchronous reset, active-high.
REQ-006 Port rx_data, input, 8: received byte, valid only while rx_done=1.
REQ-007 Port rx_done, input, 1: one-cycle byte strobe from uart_rx.
REQ-008 Port wr_full, input, 1: full flag of the SDRAM write FIFO.
REQ-009 Port wr_data, output, 16: RGB565 pixel to the SDRAM write FIFO.
REQ-010 Port wr_en, output, 1: write strobe to the SDRAM write FIFO.
REQ-011 Port frame_done, output, 1: one-cycle pulse when the last pixel of a frame enters the buffer.
REQ-012 Port overflow, output, 1: sticky flag, set when a completed pixel was dropped.
REQ-013 Port pixel_cnt, output, 19: number of pixels buffered in the current frame.

Function
REQ-014 Two-state FSM: S_HI (awaiting first byte) and S_LO (awaiting second byte).
REQ-015 In S_HI, rx_done=1 latches rx_data as the high byte and moves the FSM to S_LO.
REQ-016 In S_LO, rx_done=1 forms the pixel {high byte, rx_data}, pushes it into the buffer and returns the FSM to S_HI.
REQ-017 The pixel buffer is an internal 4-entry FIFO holding 16-bit pixels.
REQ-018 wr_en = (FIFO not empty) AND NOT wr_full, combinational; wr_data = FIFO head; the head pops on every cycle where wr_en=1.
REQ-019 Latency: a second-byte strobe in cycle N gives wr_en=1 in cycle N+1 when the FIFO was empty and wr_full=0.
REQ-020 A push is accepted when the FIFO count is below 4, or when a pop occurs in the same cycle.
REQ-021 Otherwise the pixel is discarded, overflow is set to 1, pixel_cnt is unchanged, and the FSM still returns to S_HI.
REQ-022 pixel_cnt increments by 1 on each accepted push.
REQ-023 On the accepted push that makes the count IMG_H*IMG_V, pixel_cnt wraps to 0 and frame_done pulses in the next cycle.
REQ-024 A simultaneous push and pop leaves the FIFO count unchanged and preserves order.
REQ-025 wr_data is held stable, and wr_en stays 0, while wr_full=1.
REQ-026 overflow clears only on rst.

Reset
REQ-027 On rst=1 at a clock edge: FSM to S_HI; FIFO emptied; pixel_cnt=0; overflow=0; frame_done=0; wr_en=0; wr_data=0; high-byte register=0; timeout counter=0.
REQ-028 A reset taken in S_LO or with the FIFO non-empty discards the partial byte and all buffered pixels, with no further wr_en.
REQ-029 rst has priority over rx_done in the same cycle.

Configuration
REQ-030 Macro PACKER_TIMEOUT_EN, when defined, enables gap resync.
REQ-031 With the macro defined, a counter runs while in S_LO and clears on entry to S_LO.
REQ-032 With the macro defined, the FSM returns to S_HI with the high byte discarded when TIMEOUT_CYC cycles elapse without rx_done; pixel_cnt and overflow are unaffected.
REQ-033 With the macro defined, rx_done in the same cycle as timeout expiry wins, and the byte completes the pixel.
REQ-034 With the macro undefined, no counter exists and S_LO waits indefinitely.

Verification
REQ-035 Bytes 0xF8 then 0x1F with wr_full=0 -> single wr_en pulse with wr_data=0xF81F, one cycle after the second strobe; pixel_cnt=1.
REQ-036 wr_full=1 held while 6 pixels arrive -> 4 buffered, 2 dropped, overflow=1, pixel_cnt=4; after wr_full falls, 4 wr_en pulses in order.
REQ-037 IMG_H=4, IMG_V=2, 16 bytes sent -> frame_done pulses once after the 8th pixel; pixel_cnt=0 afterwards.
REQ-038 With PACKER_TIMEOUT_EN and TIMEOUT_CYC=100: byte 0xAA, a 150-cycle gap, then 0x12, 0x34 -> only pixel 0x1234 is written.
REQ-039 rst asserted one cycle after the first byte of a pair -> no wr_en follows; the next pair 0x00, 0xFF yields 0x00FF.
REQ-040 Timeout expiry coincident with rx_done of 0x55 after high byte 0x0F -> pixel 0x0F55 is written.
